// File: rtl/div.sv
`default_nettype none
// ============================================================================
// Module   : div
// Purpose  : Sequential 32-bit restoring divider for the execute stage.
//            Performs signed (DIV) or unsigned (DIVU) division, one quotient
//            bit per clock, and returns {remainder, quotient} for HI/LO.
//            Divide by zero yields 0; 0x80000000 / -1 wraps to 0x80000000.
// Ports    : clk          - system clock, rising edge
//            rst          - synchronous active-high reset
//            signed_div_i - 1 = signed, 0 = unsigned
//            opdata1_i    - dividend
//            opdata2_i    - divisor
//            start_i      - request, held high until ready_o is seen
//            annul_i      - abort current operation (pipeline flush)
//            result_o     - {remainder[63:32], quotient[31:0]}
//            ready_o      - result valid
// Config   : DIV_EARLY_EXIT_EN - when defined, |dividend| < |divisor|
//            completes straight from IDLE (quotient 0, remainder dividend).
// Revision : 1.0 - initial release
// ============================================================================
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  localparam logic [5:0] C_LAST_STEP = 6'd31;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_work;     // {partial remainder, dividend/quotient}
  logic [31:0] r_divisor;  // divisor magnitude
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_res;      // final value, published in END

  // Operand magnitudes and signs (signs only matter in signed mode)
  logic        w_sign1;
  logic        w_sign2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;

  assign w_sign1 = signed_div_i & opdata1_i[31];
  assign w_sign2 = signed_div_i & opdata2_i[31];
  assign w_mag1  = w_sign1 ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_mag2  = w_sign2 ? (~opdata2_i + 32'd1) : opdata2_i;

  // One restoring step. The conceptual 65-bit {remainder, dividend} register
  // is held in 64 bits: after the left shift, the bit that would occupy
  // position 64 is r_work[63], so it is folded into the 33-bit trial operand.
  logic [32:0] w_upper;
  logic        w_trial_neg;
  logic [31:0] w_diff;
  logic [63:0] w_step;

  assign w_upper     = r_work[63:31];
  assign w_trial_neg = (w_upper < {1'b0, r_divisor});
  // When the trial is non-negative the true difference is below the divisor,
  // so the low 32 bits of the subtraction are exact.
  assign w_diff      = w_upper[31:0] - r_divisor;
  assign w_step      = w_trial_neg ? {r_work[62:0], 1'b0}
                                   : {w_diff, r_work[30:0], 1'b1};

  // Sign fix-up applied to the value produced by the final step
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_quot = r_neg_q ? (~w_step[31:0]  + 32'd1) : w_step[31:0];
  assign w_rem  = r_neg_r ? (~w_step[63:32] + 32'd1) : w_step[63:32];

`ifdef DIV_EARLY_EXIT_EN
  logic w_early;
  assign w_early = (w_mag1 < w_mag2);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_work    <= 64'd0;
      r_divisor <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_res     <= 64'd0;
      result_o  <= 64'd0;
      ready_o   <= 1'b0;
    end else if (annul_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i) begin
            r_work    <= {32'd0, w_mag1};
            r_divisor <= w_mag2;
            r_neg_q   <= w_sign1 ^ w_sign2;
            r_neg_r   <= w_sign1;
            r_cnt     <= 6'd0;
            if (opdata2_i == 32'd0) begin
              r_state <= S_BYZERO;
`ifdef DIV_EARLY_EXIT_EN
            end else if (w_early) begin
              // Quotient is zero and the remainder is the dividend itself,
              // sign included, so no fix-up is needed.
              r_res   <= {opdata1_i, 32'd0};
              r_state <= S_END;
`endif
            end else begin
              r_state <= S_ON;
            end
          end
        end

        S_BYZERO: begin
          r_res   <= 64'd0;
          r_state <= S_END;
        end

        S_ON: begin
          r_work <= w_step;
          r_cnt  <= r_cnt + 6'd1;
          // The 32nd step lands its fixed-up result directly in r_res so
          // that ready_o rises on the following edge.
          if (r_cnt == C_LAST_STEP) begin
            r_res   <= {w_rem, w_quot};
            r_state <= S_END;
          end
        end

        S_END: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= r_res;
          end else begin
            ready_o  <= 1'b0;
            result_o <= 64'd0;
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          ready_o  <= 1'b0;
          result_o <= 64'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_div
// Purpose  : Directed self-checking bench for the sequential divider.
//            Checks reset values, result, latency, hold and release of
//            results, signed corner cases, divide by zero, reset and annul
//            during an operation, and the small-dividend case.
// Config   : DIV_EARLY_EXIT_EN changes only the expected small-dividend
//            latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef DIV_EARLY_EXIT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 33;
`endif

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request and wait (bounded) for ready_o. lat counts edges after
  // the start-sampling edge up to the first one showing ready_o high.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_o) break;
    end
    res = result_o;
  endtask

  // Lower start_i and confirm outputs clear on that edge
  task automatic release_req(input string tag);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rel_ready"},  {63'd0, ready_o}, 64'd0);
    check({tag, "_rel_result"}, result_o, 64'd0);
  endtask

  // Full transaction: result, latency, hold for a few cycles, release
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int          lat;
    logic [63:0] res;
    run_div(sgn, a, b, lat, res);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, res, exp);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_ready"},  {63'd0, ready_o}, 64'd1);
    check({tag, "_hold_result"}, result_o, exp);
    release_req(tag);
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    logic        seen;

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready",  {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned 100 / 7 = 14 r 2
    do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    // Unsigned large: 0xFFFFFFFF / 16 = 0x0FFFFFFF r 15
    do_div("u_big", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'h0000_000F, 32'h0FFF_FFFF}, 33);
    // Same bit pattern signed: -1 / 16 = 0 r -1
    do_div("s_m1_16", 1'b1, 32'hFFFF_FFFF, 32'd16, {32'hFFFF_FFFF, 32'h0000_0000}, 33);
    // Signed -100 / 7 = -14 r -2
    do_div("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
    // Signed 100 / -7 = -14 r 2
    do_div("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 33);
    // Signed -7 / -2 = 3 r -1
    do_div("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003}, 33);
    // Overflow wrap
    do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33);
    // Divide by zero
    do_div("zero", 1'b0, 32'd5, 32'd0, 64'd0, 2);

    // Reset in the middle of an operation
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_on_ready",  {63'd0, ready_o}, 64'd0);
    check("rst_on_result", result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    seen    = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= ready_o;
    end
    check("rst_on_no_ready", {63'd0, seen}, 64'd0);

    // Annul at iteration 10, then a fresh small-dividend request
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_ready",  {63'd0, ready_o}, 64'd0);
    check("annul_result", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    run_div(1'b0, 32'd3, 32'd10, lat, res);
    check("small_lat", 64'(lat), 64'(LAT_SMALL));
    check("small_res", res, {32'd3, 32'd0});
    release_req("small");

    // Signed small dividend keeps its sign in the remainder
    do_div("s_small", 1'b1, 32'hFFFF_FFFD, 32'd10, {32'hFFFF_FFFD, 32'd0}, LAT_SMALL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
